fir_mac_stream: RTL
===================

// Module: fir_mac_stream
// PURPOSE
//   Streaming direct-form FIR filter with one shared multiply-accumulate unit. Each accepted
//   sample triggers TAPS MAC cycles, then presents one filtered output under a valid/ready handshake.
//   Coefficients are runtime-writable. Successor to the batch-mode filter: it streams instead of
//   buffering a whole signal and is parametrised in widths and taps. Sits between the sample source
//   and the RNS/output stages.
// PARAMETERS
//   DATA_W    16     sample and output width
//   COEF_W    16     coefficient width
//   TAPS      32     filter length, >=2
//   ACC_W     DATA_W+COEF_W+$clog2(TAPS)   accumulator width
//   OUT_SHIFT 15     right shift applied to acc before output (fixed-point scaling), 0..ACC_W-1
//   MODULUS   65521  residue modulus, used only with FIR_MOD_EN, < 2**DATA_W and < 2**COEF_W
// PORTS
//   clk        in   1                   clock
//   reset      in   1                   synchronous, active-high
//   coef_we    in   1                   coefficient write strobe
//   coef_addr  in   $clog2(TAPS)        coefficient index k (tap applied to x[n-k])
//   coef_wdata in   COEF_W              coefficient value
//   flush      in   1                   clear delay line and abort current sample
//   in_valid   in   1                   sample valid
//   in_ready   out  1                   block can accept a sample
//   in_data    in   DATA_W              sample
//   out_valid  out  1                   output valid
//   out_ready  in   1                   consumer accepts output
//   out_data   out  DATA_W              filtered sample
//   busy       out  1                   high in MAC or OUT state
// BEHAVIOUR
//   Reset: state=IDLE; delay line, coefficients, acc, wptr, tap counter=0; out_valid=0,
//     out_data=0, busy=0; in_ready=0 during the reset cycle, then 1 in IDLE.
//   Delay line: circular buffer of TAPS samples; wptr advances mod TAPS on each accepted sample.
//   FSM:
//     IDLE: in_ready=1. When in_valid, store in_data at wptr, clear acc and k, go to MAC.
//     MAC: one product per cycle, acc += coef[k]*x[(wptr_new-k) mod TAPS]. k runs 0..TAPS-1.
//       After k=TAPS-1, go to OUT and register out_data. in_ready=0.
//     OUT: out_valid=1 and out_data held stable until out_ready. On handshake, out_valid=0 next
//       cycle and go to IDLE. in_ready=0.
//   Latency: sample accepted at edge t, then out_valid=1 at edge t+TAPS+1. With out_ready held
//     high, throughput is 1 sample per TAPS+2 cycles.
//   Arithmetic (default): samples and coefficients are signed two's complement. Each product is
//     sign-extended to ACC_W and added with wrap in ACC_W. Output = (acc + 2**(OUT_SHIFT-1)) >>>
//     OUT_SHIFT (no rounding term when OUT_SHIFT=0), then saturated to the signed DATA_W range.
//   Coefficient writes:
//     Accepted only in IDLE, and take effect for the next sample.
//     coef_we in MAC/OUT is ignored (no write).
//     coef_we in IDLE in the same cycle as a sample accept: the write lands first, so the new
//       coefficient is used for that sample.
//   flush: in any state, the next cycle has delay line=0, wptr=0, acc=0, state=IDLE and
//     out_valid=0. A pending output is dropped. Coefficients are kept. If flush and in_valid are
//     high together, flush wins and the sample is not accepted.
//   reset mid-MAC or in OUT: same as the reset values above, and coefficients are cleared.
//   Priority: reset > flush > coef write > sample accept.
// CONFIGURATION
//   FIR_MOD_EN defined: residue mode for the RNS datapath.
//     Samples and coefficients are unsigned residues < MODULUS.
//     Each product is reduced mod MODULUS, and acc = (acc + prod_mod) mod MODULUS via conditional
//       subtract.
//     out_data = acc, with no shift, rounding or saturation. OUT_SHIFT is ignored.
//     Latency is unchanged; the reduction sits inside the MAC cycle.
//   FIR_MOD_EN undefined: signed fixed-point arithmetic as above; MODULUS is unused.
// TESTING
//   1 Impulse: TAPS=4, OUT_SHIFT=0, coefs {1,2,3,4}; feed 1,0,0,0,0 -> outputs 1,2,3,4,0.
//   2 Latency/handshake: in_valid at edge t -> out_valid at t+TAPS+1. Hold out_ready=0 for 5
//     cycles -> out_data stable, in_ready=0. Then out_ready=1 -> IDLE, in_ready=1.
//   3 Saturation/rounding: DATA_W=16, OUT_SHIFT=15, all coefs 0x7FFF, in 0x7FFF repeated ->
//     out saturates at 0x7FFF. All coefs 0x8000 and in 0x7FFF -> out 0x8000.
//     One tap of 0x4000 with in=1 -> out 1 (round half up).
//   4 Flush/coef-ignore: flush at MAC cycle 2 -> no out_valid, next output computes as if from an
//     empty history. coef_we asserted during MAC -> coefficient unchanged.
//   5 Reset mid-OUT: assert reset with out_valid=1 -> out_valid=0, out_data=0, all coefs read 0,
//     and the next sample's output is 0.
//   6 FIR_MOD_EN, MODULUS=7, TAPS=2, coefs {3,5}; feed 4,6 -> outputs 5, (3*6+5*4) mod 7 = 3.

Source files
------------

// File: rtl/fir_mac_stream.sv
// fir_mac_stream: streaming direct-form FIR filter built around one shared MAC.
//   Each accepted sample triggers TAPS multiply-accumulate cycles. The filtered
//   result is then held under a valid/ready handshake until the consumer takes it.
//   Coefficients are writable at runtime, but only while the block is idle.
//
// Build option: define FIR_MOD_EN for residue (mod MODULUS) arithmetic for the RNS
//   datapath. Without it, samples and coefficients are signed fixed point and the
//   output is rounded, shifted and saturated.
//
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   coef_we/coef_addr/coef_wdata coefficient write port (tap k applies to x[n-k])
//   flush                        clear delay line and abort the current sample
//   in_valid/in_ready/in_data    sample input handshake
//   out_valid/out_ready/out_data filtered output handshake
//   busy                         high while in MAC or OUT
module fir_mac_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAPS      = 32,
  parameter int unsigned ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int unsigned OUT_SHIFT = 15,
  parameter int unsigned MODULUS   = 65521
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_dline [TAPS];
  logic [COEF_W-1:0]   r_coef  [TAPS];
  logic [ACC_W-1:0]    r_acc;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW-1:0]       r_k;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_busy;

  logic                w_accept;
  logic                w_coef_wr;
  logic                w_last_k;
  logic [DATA_W-1:0]   w_x;
  logic [COEF_W-1:0]   w_c;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [DATA_W-1:0]   w_out_val;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

  // Flush outranks both coefficient writes and sample accepts.
  assign w_accept  = (r_state == S_IDLE) && r_in_ready && in_valid && !flush;
  assign w_coef_wr = (r_state == S_IDLE) && coef_we && !flush && (32'(coef_addr) < TAPS);
  assign w_last_k  = (r_k == AW'(TAPS - 1));
  assign w_x       = r_dline[r_rptr];
  assign w_c       = r_coef[r_k];

`ifdef FIR_MOD_EN
  // Residue MAC: reduce the product, then keep acc < MODULUS with one conditional subtract.
  logic [PW-1:0]    w_prod_u;
  logic [ACC_W-1:0] w_prod_mod;
  logic [ACC_W-1:0] w_sum;

  assign w_prod_u   = PW'(w_x) * PW'(w_c);
  assign w_prod_mod = ACC_W'(w_prod_u % PW'(MODULUS));
  assign w_sum      = r_acc + w_prod_mod;
  assign w_acc_nxt  = (w_sum >= ACC_W'(MODULUS)) ? (w_sum - ACC_W'(MODULUS)) : w_sum;
  assign w_out_val  = DATA_W'(w_acc_nxt);
`else
  // Signed MAC, then round half up, arithmetic shift and saturate to DATA_W.
  localparam int unsigned RND_SH = (OUT_SHIFT > 0) ? (OUT_SHIFT - 1) : 0;
  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [PW-1:0] w_prod;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_shf;

  assign w_prod    = PW'($signed(w_x)) * PW'($signed(w_c));
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);
  // One extra bit so the rounding term cannot wrap the accumulator.
  assign w_rnd     = $signed({w_acc_nxt[ACC_W-1], w_acc_nxt}) + RND;
  assign w_shf     = w_rnd >>> OUT_SHIFT;
  assign w_out_val = (w_shf > SAT_MAX) ? DATA_W'(SAT_MAX) :
                     (w_shf < SAT_MIN) ? DATA_W'(SAT_MIN) :
                                         DATA_W'(w_shf);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_MAC;
      S_MAC:   if (w_last_k)  w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Registered handshake and status outputs follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Coefficient store: cleared by reset only, so it survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // Delay line, pointers and accumulator. The read pointer walks backwards from
  // the newest sample so tap k meets x[n-k].
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < int'(TAPS); i++) r_dline[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_k    <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_dline[r_wptr] <= in_data;
      r_rptr          <= r_wptr;
      r_wptr          <= (r_wptr == AW'(TAPS - 1)) ? '0 : (r_wptr + AW'(1));
      r_k             <= '0;
      r_acc           <= '0;
    end else if (r_state == S_MAC) begin
      r_acc  <= w_acc_nxt;
      r_k    <= w_last_k ? '0 : (r_k + AW'(1));
      r_rptr <= (r_rptr == '0) ? AW'(TAPS - 1) : (r_rptr - AW'(1));
    end
  end

  // Output data captured from the final MAC sum; held through OUT and after.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
    end else if (!flush && (r_state == S_MAC) && w_last_k) begin
      r_out_data <= w_out_val;
    end
  end

endmodule
